// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch path: FSM encoding, parameter defaults
// and return-stack geometry.
package cpu_pkg;

    typedef enum logic [1:0] {
        INICIO  = 2'd0,
        BUSCA   = 2'd1,
        ENTREGA = 2'd2
    } estado_t;

    localparam int ADDR_W_DEF   = 16;
    localparam int INSTR_W_DEF  = 32;
    localparam int RESET_PC_DEF = 0;

    localparam int PILHA_PROF  = 4;
    localparam int PILHA_PTR_W = $clog2(PILHA_PROF);
    localparam int PILHA_CNT_W = PILHA_PTR_W + 1;

endpackage

// File: rtl/pilha_retorno.sv
// Circular return-address stack; a push when full overwrites the oldest entry,
// and the top of an empty stack reads as RESET_PC.
module pilha_retorno
    import cpu_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int RESET_PC = RESET_PC_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_end,
    output logic [ADDR_W-1:0] topo
);

    localparam logic [PILHA_CNT_W-1:0] CHEIO = PILHA_CNT_W'(PILHA_PROF);

    logic [PILHA_PROF-1:0][ADDR_W-1:0] mem_q, mem_d;
    logic [PILHA_PTR_W-1:0]            ptr_q, ptr_d;
    logic [PILHA_CNT_W-1:0]            cnt_q, cnt_d;

    // ptr_q is the next free slot, so the top lives one below it
    assign topo = (cnt_q == '0) ? ADDR_W'(RESET_PC) : mem_q[ptr_q - PILHA_PTR_W'(1)];

    always_comb begin
        mem_d = mem_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (pop) begin
            if (cnt_q != '0) begin
                ptr_d = ptr_q - PILHA_PTR_W'(1);
                cnt_d = cnt_q - PILHA_CNT_W'(1);
            end
        end else if (push) begin
            mem_d[ptr_q] = push_end;
            ptr_d        = ptr_q + PILHA_PTR_W'(1);
            if (cnt_q != CHEIO)
                cnt_d = cnt_q + PILHA_CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mem_q <= '0;
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: INICIO/BUSCA/ENTREGA FSM with branch redirect and stall.
// Define RETURN_STACK_EN to add call/return handling through pilha_retorno.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int INSTR_W  = INSTR_W_DEF,
    parameter int RESET_PC = RESET_PC_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               salto,
    input  logic [ADDR_W-1:0]  destino,
    input  logic               parar,
    input  logic               chamada,
    input  logic               retorno,
    input  logic               mem_pronto,
    input  logic [INSTR_W-1:0] mem_dado,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_end,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valido,
    output logic [ADDR_W-1:0]  pc_atual
);

    localparam logic [ADDR_W-1:0] PC_INI = ADDR_W'(RESET_PC);

    estado_t              estado_q, estado_d;
    logic [ADDR_W-1:0]    pc_q, pc_d;
    logic [ADDR_W-1:0]    alvo_q, alvo_d;
    logic [ADDR_W-1:0]    pc_atual_q, pc_atual_d;
    logic [INSTR_W-1:0]   instr_q, instr_d;
    logic                 pend_q, pend_d;
    logic                 mem_req_q, mem_req_d;
    logic                 valido_q, valido_d;

    logic                 ret_ativo;
    logic [ADDR_W-1:0]    ret_alvo;
    logic                 redir;
    logic [ADDR_W-1:0]    redir_alvo;

`ifdef RETURN_STACK_EN
    logic ativo, push, pop;

    assign ativo     = (estado_q != INICIO);
    assign ret_ativo = retorno;
    assign pop       = ativo && retorno;
    // return pops win over a simultaneous call push
    assign push      = ativo && salto && chamada && !retorno;

    pilha_retorno #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pilha (
        .clock    (clock),
        .reset    (reset),
        .push     (push),
        .pop      (pop),
        .push_end (pc_atual_q + ADDR_W'(1)),
        .topo     (ret_alvo)
    );
`else
    logic unused_cfg;

    assign ret_ativo  = 1'b0;
    assign ret_alvo   = PC_INI;
    assign unused_cfg = chamada ^ retorno;
`endif

    assign redir      = salto || ret_ativo;
    assign redir_alvo = ret_ativo ? ret_alvo : destino;

    always_comb begin
        estado_d   = estado_q;
        pc_d       = pc_q;
        alvo_d     = alvo_q;
        pc_atual_d = pc_atual_q;
        instr_d    = instr_q;
        pend_d     = pend_q;
        mem_req_d  = mem_req_q;
        valido_d   = valido_q;
        case (estado_q)
            INICIO: begin
                estado_d  = BUSCA;
                mem_req_d = 1'b1;
            end
            BUSCA: begin
                if (redir) begin
                    pend_d = 1'b1;
                    alvo_d = redir_alvo;
                end
                if (mem_pronto) begin
                    if (redir || pend_q) begin
                        // stale word: refetch at the redirect target
                        pc_d   = redir ? redir_alvo : alvo_q;
                        pend_d = 1'b0;
                    end else begin
                        instr_d    = mem_dado;
                        pc_atual_d = pc_q;
                        valido_d   = 1'b1;
                        mem_req_d  = 1'b0;
                        estado_d   = ENTREGA;
                    end
                end
            end
            ENTREGA: begin
                if (parar) begin
                    if (redir) begin
                        pend_d = 1'b1;
                        alvo_d = redir_alvo;
                    end
                end else begin
                    valido_d  = 1'b0;
                    mem_req_d = 1'b1;
                    pend_d    = 1'b0;
                    estado_d  = BUSCA;
                    if (redir)       pc_d = redir_alvo;
                    else if (pend_q) pc_d = alvo_q;
                    else             pc_d = pc_q + ADDR_W'(1);
                end
            end
            default: begin
                estado_d  = INICIO;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q   <= INICIO;
            pc_q       <= PC_INI;
            alvo_q     <= '0;
            pc_atual_q <= '0;
            instr_q    <= '0;
            pend_q     <= 1'b0;
            mem_req_q  <= 1'b0;
            valido_q   <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            pc_q       <= pc_d;
            alvo_q     <= alvo_d;
            pc_atual_q <= pc_atual_d;
            instr_q    <= instr_d;
            pend_q     <= pend_d;
            mem_req_q  <= mem_req_d;
            valido_q   <= valido_d;
        end
    end

    assign mem_req      = mem_req_q;
    assign mem_end      = pc_q;
    assign instr        = instr_q;
    assign instr_valido = valido_q;
    assign pc_atual     = pc_atual_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: stimulus queues expected deliveries, a monitor
// pops and compares them on every new instr_valido.
module tb_fetch_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        salto = 1'b0, parar = 1'b0, chamada = 1'b0, retorno = 1'b0;
    logic        mem_pronto = 1'b0;
    logic [15:0] destino = 16'h0000;
    logic [31:0] mem_dado;
    logic        mem_req;
    logic [15:0] mem_end;
    logic [31:0] instr;
    logic        instr_valido;
    logic [15:0] pc_atual;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] pc;
        logic [31:0] ins;
    } esp_t;
    esp_t sb_q[$];

    always #5 clock = ~clock;

    function automatic logic [31:0] palavra(input logic [15:0] a);
        return 32'hC0DE_0000 | {16'h0000, a};
    endfunction

    assign mem_dado = palavra(mem_end);

    fetch_unit dut (
        .clock        (clock),
        .reset        (reset),
        .salto        (salto),
        .destino      (destino),
        .parar        (parar),
        .chamada      (chamada),
        .retorno      (retorno),
        .mem_pronto   (mem_pronto),
        .mem_dado     (mem_dado),
        .mem_req      (mem_req),
        .mem_end      (mem_end),
        .instr        (instr),
        .instr_valido (instr_valido),
        .pc_atual     (pc_atual)
    );

    task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nome, act, exp, $time);
        end
    endtask

    task automatic passo();
        @(negedge clock);
    endtask

    // Called at a negedge in BUSCA; returns at the negedge in ENTREGA.
    task automatic busca(input logic [15:0] addr, input int esperas);
        esp_t e;
        for (int k = 0; k < esperas; k++) begin
            chk("espera_req", {31'd0, mem_req}, 32'd1);
            chk("espera_end", {16'd0, mem_end}, {16'd0, addr});
            chk("espera_valido", {31'd0, instr_valido}, 32'd0);
            mem_pronto = 1'b0;
            passo();
        end
        chk("busca_req", {31'd0, mem_req}, 32'd1);
        chk("busca_end", {16'd0, mem_end}, {16'd0, addr});
        e.pc  = addr;
        e.ins = palavra(addr);
        sb_q.push_back(e);
        mem_pronto = 1'b1;
        passo();
        mem_pronto = 1'b0;
        chk("entrega_req", {31'd0, mem_req}, 32'd0);
    endtask

    // Called at a negedge in ENTREGA; redirect seen with parar=0.
    task automatic salta(input logic [15:0] d, input logic c, input logic r, input logic s);
        salto = s; chamada = c; retorno = r; destino = d;
        passo();
        salto = 1'b0; chamada = 1'b0; retorno = 1'b0; destino = 16'h0000;
    endtask

    initial begin : monitor
        logic prev;
        esp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clock);
            if (instr_valido === 1'b1 && prev !== 1'b1) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL entrega_extra: pc_atual=%h instr=%h with nothing expected", pc_atual, instr);
                end else begin
                    e = sb_q.pop_front();
                    chk("entrega_pc", {16'd0, pc_atual}, {16'd0, e.pc});
                    chk("entrega_instr", instr, e.ins);
                end
            end
            prev = instr_valido;
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : estimulo
        logic [15:0] alvos [5];
        logic [15:0] rets  [5];
        alvos = '{16'h0300, 16'h0310, 16'h0320, 16'h0330, 16'h0340};
        rets  = '{16'h0331, 16'h0321, 16'h0311, 16'h0301, 16'h0000};

        passo();
        passo();
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_valido", {31'd0, instr_valido}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_pc_atual", {16'd0, pc_atual}, 32'd0);
        chk("rst_end", {16'd0, mem_end}, 32'd0);
        reset = 1'b0;
        passo();

        // sequential fetch, three wait states at address 5
        for (int a = 0; a < 7; a++) begin
            busca(16'(a), (a == 5) ? 3 : 0);
            passo();
        end
        busca(16'h0007, 0);

        // branch in ENTREGA
        salta(16'h0040, 1'b0, 1'b0, 1'b1);
        busca(16'h0040, 0);

        // stall
        parar = 1'b1;
        repeat (4) begin
            passo();
            chk("stall_instr", instr, palavra(16'h0040));
            chk("stall_pc", {16'd0, pc_atual}, 32'h0040);
            chk("stall_valido", {31'd0, instr_valido}, 32'd1);
            chk("stall_req", {31'd0, mem_req}, 32'd0);
        end
        parar = 1'b0;
        passo();
        busca(16'h0041, 0);

        // branch while waiting in BUSCA discards the outstanding word
        salta(16'h0009, 1'b0, 1'b0, 1'b1);
        chk("b9_end", {16'd0, mem_end}, 32'h0009);
        salto = 1'b1; destino = 16'h0100;
        passo();
        salto = 1'b0; destino = 16'h0000;
        chk("b9_pend_end", {16'd0, mem_end}, 32'h0009);
        chk("b9_pend_req", {31'd0, mem_req}, 32'd1);
        mem_pronto = 1'b1;
        passo();
        mem_pronto = 1'b0;
        chk("b9_descarte", {31'd0, instr_valido}, 32'd0);
        busca(16'h0100, 0);

        // PC+1 wraps
        salta(16'hFFFF, 1'b0, 1'b0, 1'b1);
        busca(16'hFFFF, 0);
        passo();
        busca(16'h0000, 0);

`ifndef RETURN_STACK_EN
        salta(16'h0000, 1'b1, 1'b1, 1'b0);
        busca(16'h0001, 0);
        salta(16'h0020, 1'b1, 1'b0, 1'b1);
        busca(16'h0020, 0);
        salta(16'h0000, 1'b0, 1'b1, 1'b0);
        busca(16'h0021, 0);
`endif

        // reset with a request outstanding
        passo();
        chk("rst2_req_antes", {31'd0, mem_req}, 32'd1);
        mem_pronto = 1'b1;
        reset = 1'b1;
        passo();
        reset = 1'b0;
        chk("rst2_req", {31'd0, mem_req}, 32'd0);
        chk("rst2_valido", {31'd0, instr_valido}, 32'd0);
        chk("rst2_end", {16'd0, mem_end}, 32'd0);
        passo();
        chk("rst2_ignora", {31'd0, instr_valido}, 32'd0);
        busca(16'h0000, 0);

`ifdef RETURN_STACK_EN
        salta(16'h0010, 1'b0, 1'b0, 1'b1);
        busca(16'h0010, 0);
        salta(16'h0200, 1'b1, 1'b0, 1'b1);
        busca(16'h0200, 0);
        salta(16'h0000, 1'b0, 1'b1, 1'b0);
        busca(16'h0011, 0);
        for (int i = 0; i < 5; i++) begin
            salta(alvos[i], 1'b1, 1'b0, 1'b1);
            busca(alvos[i], 0);
        end
        for (int i = 0; i < 5; i++) begin
            salta(16'h0000, 1'b0, 1'b1, 1'b0);
            busca(rets[i], 0);
        end
`endif

        passo();
        passo();
        passo();
        chk("sb_vazio", sb_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
